// File: rtl/traffic_sig_ctrl_if.sv
// rtl/traffic_sig_ctrl_if.sv - sensor/button inputs and lamp/status outputs of the traffic controller
//
// Signals:
//   X        country-road vehicle sensor (level)
//   ped_req  pedestrian button (pulse)
//   hwy      highway lamp     RED=0 YELLOW=1 GREEN=2
//   cntry    country lamp     same encoding
//   ped_walk walk signal
//   ped_wait pedestrian request pending
//   state_o  current state code (debug)
// The master modport is the environment; the slave modport is the controller.
interface traffic_sig_ctrl_if;
    logic       X;
    logic       ped_req;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       ped_walk;
    logic       ped_wait;
    logic [2:0] state_o;

    modport master (
        output X,
        output ped_req,
        input  hwy,
        input  cntry,
        input  ped_walk,
        input  ped_wait,
        input  state_o
    );

    modport slave (
        input  X,
        input  ped_req,
        output hwy,
        output cntry,
        output ped_walk,
        output ped_wait,
        output state_o
    );
endinterface

// File: rtl/traffic_sig_ctrl.sv
// rtl/traffic_sig_ctrl.sv - highway/country road signal controller with pedestrian phase
//
// Ports:
//   clock  rising-edge clock for all state
//   clear  synchronous active-high reset; loads HG, timer 0, no pending request
//   bus    traffic_sig_ctrl_if.slave: X, ped_req in; hwy, cntry, ped_walk, ped_wait, state_o out
// Parameters: TW timer width; GREEN_MIN, YELLOW_TIME, ALLRED_TIME, PED_TIME, CNTRY_MAX
// phase durations in cycles, each in 1 .. 2^TW-1, with CNTRY_MAX >= GREEN_MIN.
module traffic_sig_ctrl #(
    parameter int TW          = 8,
    parameter int GREEN_MIN   = 4,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2,
    parameter int PED_TIME    = 5,
    parameter int CNTRY_MAX   = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    traffic_sig_ctrl_if.slave    bus
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_PED = 3'd3,
        S_CG  = 3'd4,
        S_CY  = 3'd5,
        S_AR2 = 3'd6,
        S_BAD = 3'd7
    } state_t;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    // Timer value seen in the last cycle of each phase (timer counts from 0).
    localparam logic [TW-1:0] L_GREEN_LAST  = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] L_YELLOW_LAST = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] L_ALLRED_LAST = TW'(ALLRED_TIME - 1);
    localparam logic [TW-1:0] L_PED_LAST    = TW'(PED_TIME - 1);
    localparam logic [TW-1:0] L_CNTRY_LAST  = TW'(CNTRY_MAX - 1);
    localparam logic [TW-1:0] L_TIMER_MAX   = {TW{1'b1}};
    localparam logic [TW-1:0] L_TIMER_ONE   = TW'(1);

    state_t          r_state;
    state_t          w_next;
    logic [TW-1:0]   r_timer;
    logic            r_ped_wait;
    logic            w_ped_go;
    logic [1:0]      w_hwy;
    logic [1:0]      w_cntry;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_HG;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_ped_go = 1'b0;
        case (r_state)
            S_HG: begin
                if (r_timer >= L_GREEN_LAST && (bus.X || r_ped_wait)) begin
                    w_next = S_HY;
                end
            end
            S_HY: begin
                if (r_timer == L_YELLOW_LAST) begin
                    w_next = S_AR1;
                end
            end
            S_AR1: begin
                if (r_timer == L_ALLRED_LAST) begin
                    if (r_ped_wait) begin
                        w_next   = S_PED;
                        w_ped_go = 1'b1;
                    end else begin
                        w_next = S_CG;
                    end
                end
            end
            S_PED: begin
                if (r_timer == L_PED_LAST) begin
                    w_next = bus.X ? S_CG : S_HG;
                end
            end
            S_CG: begin
                // Minimum green once the country road empties; hard cap otherwise.
                if ((r_timer >= L_GREEN_LAST && !bus.X) || r_timer == L_CNTRY_LAST) begin
                    w_next = S_CY;
                end
            end
            S_CY: begin
                if (r_timer == L_YELLOW_LAST) begin
                    w_next = S_AR2;
                end
            end
            S_AR2: begin
                if (r_timer == L_ALLRED_LAST) begin
                    w_next = S_HG;
                end
            end
            default: begin
                w_next = S_HG;
            end
        endcase
    end

    // Phase timer and pedestrian latch. The latch is cleared on the edge that
    // enters PED, and button presses on that edge or during PED are dropped
    // because that walk phase already serves them.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_timer    <= '0;
            r_ped_wait <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_timer != L_TIMER_MAX) begin
                r_timer <= r_timer + L_TIMER_ONE;
            end

            if (w_ped_go) begin
                r_ped_wait <= 1'b0;
            end else if (bus.ped_req && r_state != S_PED) begin
                r_ped_wait <= 1'b1;
            end
        end
    end

    always_comb begin
        w_hwy   = LAMP_RED;
        w_cntry = LAMP_RED;
        case (r_state)
            S_HG:    w_hwy   = LAMP_GREEN;
            S_HY:    w_hwy   = LAMP_YELLOW;
            S_CG:    w_cntry = LAMP_GREEN;
            S_CY:    w_cntry = LAMP_YELLOW;
            default: begin
                w_hwy   = LAMP_RED;
                w_cntry = LAMP_RED;
            end
        endcase
    end

    assign bus.hwy      = w_hwy;
    assign bus.cntry    = w_cntry;
    assign bus.ped_walk = (r_state == S_PED);
    assign bus.ped_wait = r_ped_wait;
    assign bus.state_o  = r_state;

endmodule

// File: tb/tb_traffic_sig_ctrl.sv
// tb/tb_traffic_sig_ctrl.sv - directed and randomized checks of traffic_sig_ctrl against a phase-duration model
module tb_traffic_sig_ctrl;

    localparam int GREEN_MIN   = 4;
    localparam int YELLOW_TIME = 3;
    localparam int ALLRED_TIME = 2;
    localparam int PED_TIME    = 5;
    localparam int CNTRY_MAX   = 8;

    localparam int P_HG = 0, P_HY = 1, P_AR1 = 2, P_PED = 3, P_CG = 4, P_CY = 5, P_AR2 = 6;

    logic clock;
    logic clear;

    traffic_sig_ctrl_if bus ();

    traffic_sig_ctrl #(
        .TW          (8),
        .GREEN_MIN   (GREEN_MIN),
        .YELLOW_TIME (YELLOW_TIME),
        .ALLRED_TIME (ALLRED_TIME),
        .PED_TIME    (PED_TIME),
        .CNTRY_MAX   (CNTRY_MAX)
    ) u_dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: current phase, cycles already spent in it, pending request.
    int m_ph   = P_HG;
    int m_el   = 0;
    int m_pend = 0;
    int hwy_tab[7]   = '{2, 1, 0, 0, 0, 0, 0};
    int cntry_tab[7] = '{0, 0, 0, 0, 2, 1, 0};

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_step(input logic x, input logic pr, input logic clr);
        int n;
        int nx;
        if (clr) begin
            m_ph = P_HG; m_el = 0; m_pend = 0;
            return;
        end
        n  = m_el + 1;
        nx = m_ph;
        case (m_ph)
            P_HG:  if (n >= GREEN_MIN && (x || m_pend != 0)) nx = P_HY;
            P_HY:  if (n == YELLOW_TIME) nx = P_AR1;
            P_AR1: if (n == ALLRED_TIME) nx = (m_pend != 0) ? P_PED : P_CG;
            P_PED: if (n == PED_TIME) nx = x ? P_CG : P_HG;
            P_CG:  if ((n >= GREEN_MIN && !x) || n == CNTRY_MAX) nx = P_CY;
            P_CY:  if (n == YELLOW_TIME) nx = P_AR2;
            P_AR2: if (n == ALLRED_TIME) nx = P_HG;
            default: nx = P_HG;
        endcase
        if (m_ph == P_AR1 && nx == P_PED) m_pend = 0;
        else if (pr && m_ph != P_PED)    m_pend = 1;
        m_el = (nx != m_ph) ? 0 : n;
        m_ph = nx;
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare 1 ns later.
    task automatic cyc(input logic x, input logic pr, input logic clr);
        bus.X       = x;
        bus.ped_req = pr;
        clear       = clr;
        @(posedge clock);
        model_step(x, pr, clr);
        #1;
        chk("m_state", int'(bus.state_o), m_ph);
        chk("m_hwy",   int'(bus.hwy),     hwy_tab[m_ph]);
        chk("m_cntry", int'(bus.cntry),   cntry_tab[m_ph]);
        chk("m_walk",  int'(bus.ped_walk), (m_ph == P_PED) ? 1 : 0);
        chk("m_wait",  int'(bus.ped_wait), m_pend);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
    endtask

    int mg_k[8] = '{3, 6, 8, 15, 16, 19, 21, 25};
    int mg_s[8] = '{1, 2, 4, 4, 5, 6, 0, 1};

    initial begin
        logic xr;
        bus.X       = 1'b0;
        bus.ped_req = 1'b0;
        clear       = 1'b1;

        // Reset state
        do_reset();
        chk("rst_hwy",   int'(bus.hwy), 2);
        chk("rst_cntry", int'(bus.cntry), 0);
        chk("rst_walk",  int'(bus.ped_walk), 0);
        chk("rst_wait",  int'(bus.ped_wait), 0);
        chk("rst_state", int'(bus.state_o), 0);

        // Idle: highway keeps green
        for (int i = 0; i < 30; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            chk("idle_state", int'(bus.state_o), 0);
            chk("idle_hwy",   int'(bus.hwy), 2);
            chk("idle_cntry", int'(bus.cntry), 0);
        end

        // Max green loop with X held: 22 cycles per loop
        do_reset();
        for (int k = 0; k <= 25; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            for (int j = 0; j < 8; j++)
                if (mg_k[j] == k) chk("maxg_state", int'(bus.state_o), mg_s[j]);
        end

        // Early exit: X drops once CG is entered, CG lasts 4 cycles
        do_reset();
        for (int k = 0; k <= 12; k++) begin
            cyc(k < 8, 1'b0, 1'b0);
            if (k == 8)  chk("early_cg_first", int'(bus.state_o), 4);
            if (k == 11) chk("early_cg_last",  int'(bus.state_o), 4);
            if (k == 12) chk("early_cy",       int'(bus.state_o), 5);
        end

        // Pedestrian pulse at cycle 1, X low
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            cyc(1'b0, k == 1, 1'b0);
            if (k == 0)  chk("ped_wait_before", int'(bus.ped_wait), 0);
            if (k == 1)  chk("ped_wait_set",    int'(bus.ped_wait), 1);
            if (k == 3)  chk("ped_hy",          int'(bus.state_o), 1);
            if (k == 8) begin
                chk("ped_enter_state", int'(bus.state_o), 3);
                chk("ped_enter_walk",  int'(bus.ped_walk), 1);
                chk("ped_enter_wait",  int'(bus.ped_wait), 0);
            end
            if (k == 12) chk("ped_last_walk", int'(bus.ped_walk), 1);
            if (k == 13) begin
                chk("ped_exit_state", int'(bus.state_o), 0);
                chk("ped_exit_walk",  int'(bus.ped_walk), 0);
            end
        end

        // Clear at timer 3 of CG together with a button press
        do_reset();
        for (int k = 0; k <= 11; k++) cyc(1'b1, 1'b0, 1'b0);
        chk("midrst_pre_cg", int'(bus.state_o), 4);
        cyc(1'b1, 1'b1, 1'b1);
        chk("midrst_state", int'(bus.state_o), 0);
        chk("midrst_hwy",   int'(bus.hwy), 2);
        chk("midrst_cntry", int'(bus.cntry), 0);
        chk("midrst_wait",  int'(bus.ped_wait), 0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk("midrst_hg_hold", int'(bus.state_o), 0);
        end
        cyc(1'b1, 1'b0, 1'b0);
        chk("midrst_hy", int'(bus.state_o), 1);

        // Randomized traffic, button presses and occasional clears
        do_reset();
        xr = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) xr = ~xr;
            cyc(xr, $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
